// File: rtl/atm_vault_pkg.sv
// Shared types and constants for the ATM cash vault: FSM states, note units, result codes.
package atm_vault_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        DISPENSE = 2'd2
    } state_t;

    localparam logic [2:0] UNIT_50K  = 3'd1;
    localparam logic [2:0] UNIT_100K = 3'd2;
    localparam logic [2:0] UNIT_200K = 3'd4;

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_OK      = 3'd1;
    localparam logic [2:0] ST_NOFUNDS = 3'd2;
    localparam logic [2:0] ST_NOCASH  = 3'd3;
    localparam logic [2:0] ST_FULL    = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;
    localparam logic [2:0] ST_ILLEGAL = 3'd6;

endpackage

// File: rtl/atm_req_decode.sv
// Combinational decode of the six request pulses into direction, note units and an illegal flag.
module atm_req_decode
    import atm_vault_pkg::*;
(
    input  logic       i_w_50000,
    input  logic       i_w_100000,
    input  logic       i_w_200000,
    input  logic       i_d_50000,
    input  logic       i_d_100000,
    input  logic       i_d_200000,
    output logic       o_req_valid,
    output logic       o_is_withdraw,
    output logic [2:0] o_units,
    output logic       o_illegal
);

    logic [2:0] w_count;

    assign w_count = {2'b00, i_w_50000}  + {2'b00, i_w_100000} + {2'b00, i_w_200000}
                   + {2'b00, i_d_50000}  + {2'b00, i_d_100000} + {2'b00, i_d_200000};

    assign o_req_valid   = (w_count == 3'd1);
    assign o_illegal     = (w_count > 3'd1);
    assign o_is_withdraw = i_w_50000 | i_w_100000 | i_w_200000;
    assign o_units       = ({3{i_w_50000  | i_d_50000}}  & UNIT_50K)
                         | ({3{i_w_100000 | i_d_100000}} & UNIT_100K)
                         | ({3{i_w_200000 | i_d_200000}} & UNIT_200K);

endmodule

// File: rtl/atm_cash_vault.sv
// ATM vault back-end: funds/stock check, dispense handshake with timeout, balance commit.
// Optional macro ATM_AUDIT_LOG_EN enables the saturating committed-transaction counter.
module atm_cash_vault
    import atm_vault_pkg::*;
#(
    parameter int BAL_W          = 24,
    parameter int NOTE_W         = 10,
    parameter int INIT_BALANCE   = 40,
    parameter int INIT_NOTES     = 100,
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              W_50000,
    input  logic              W_100000,
    input  logic              W_200000,
    input  logic              D_50000,
    input  logic              D_100000,
    input  logic              D_200000,
    input  logic              dispense_ack,
    output logic              busy,
    output logic              dispense_valid,
    output logic [2:0]        dispense_units,
    output logic              approved,
    output logic              denied,
    output logic [2:0]        status,
    output logic [BAL_W-1:0]  balance,
    output logic [NOTE_W-1:0] notes_left,
    output logic [15:0]       txn_count
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    logic              w_req_valid;
    logic              w_is_withdraw;
    logic [2:0]        w_units;
    logic              w_illegal;
    logic [BAL_W:0]    w_bal_sum;
    logic [NOTE_W:0]   w_notes_sum;
    logic              w_bal_short;
    logic              w_notes_short;
    logic              w_dep_ok;

    state_t            r_state;
    logic              r_busy;
    logic              r_valid;
    logic [2:0]        r_disp_units;
    logic              r_approved;
    logic              r_denied;
    logic [2:0]        r_status;
    logic [BAL_W-1:0]  r_balance;
    logic [NOTE_W-1:0] r_notes;
    logic              r_is_wd;
    logic [2:0]        r_units;
    logic [TMR_W-1:0]  r_timer;

    atm_req_decode u_decode (
        .i_w_50000     (W_50000),
        .i_w_100000    (W_100000),
        .i_w_200000    (W_200000),
        .i_d_50000     (D_50000),
        .i_d_100000    (D_100000),
        .i_d_200000    (D_200000),
        .o_req_valid   (w_req_valid),
        .o_is_withdraw (w_is_withdraw),
        .o_units       (w_units),
        .o_illegal     (w_illegal)
    );

    // One extra bit on each sum exposes the carry, so a deposit can be refused instead of wrapping.
    assign w_bal_sum     = {1'b0, r_balance} + (BAL_W+1)'(r_units);
    assign w_notes_sum   = {1'b0, r_notes} + (NOTE_W+1)'(r_units);
    assign w_dep_ok      = !w_bal_sum[BAL_W] && !w_notes_sum[NOTE_W];
    assign w_bal_short   = (r_balance < BAL_W'(r_units));
    assign w_notes_short = (r_notes < NOTE_W'(r_units));

    // state    | meaning
    // IDLE     | waiting for a single request pulse
    // CHECK    | one cycle: funds/stock test for withdraw, overflow test and commit for deposit
    // DISPENSE | notes offered to mechanism; down-counter timer, ack wins over terminal count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_disp_units <= '0;
            r_approved   <= 1'b0;
            r_denied     <= 1'b0;
            r_status     <= ST_NONE;
            r_balance    <= BAL_W'(INIT_BALANCE);
            r_notes      <= NOTE_W'(INIT_NOTES);
            r_is_wd      <= 1'b0;
            r_units      <= '0;
            r_timer      <= '0;
        end else begin
            r_approved <= 1'b0;
            r_denied   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_illegal) begin
                        r_denied <= 1'b1;
                        r_status <= ST_ILLEGAL;
                    end else if (w_req_valid) begin
                        r_is_wd <= w_is_withdraw;
                        r_units <= w_units;
                        r_busy  <= 1'b1;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (r_is_wd && !w_bal_short && !w_notes_short) begin
                        r_state      <= DISPENSE;
                        r_valid      <= 1'b1;
                        r_disp_units <= r_units;
                        r_timer      <= TMR_LOAD;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (r_is_wd) begin
                            r_denied <= 1'b1;
                            r_status <= w_bal_short ? ST_NOFUNDS : ST_NOCASH;
                        end else if (w_dep_ok) begin
                            r_balance  <= w_bal_sum[BAL_W-1:0];
                            r_notes    <= w_notes_sum[NOTE_W-1:0];
                            r_approved <= 1'b1;
                            r_status   <= ST_OK;
                        end else begin
                            r_denied <= 1'b1;
                            r_status <= ST_FULL;
                        end
                    end
                end
                DISPENSE: begin
                    if (dispense_ack) begin
                        r_balance    <= r_balance - BAL_W'(r_units);
                        r_notes      <= r_notes - NOTE_W'(r_units);
                        r_approved   <= 1'b1;
                        r_status     <= ST_OK;
                        r_valid      <= 1'b0;
                        r_disp_units <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else if (r_timer == '0) begin
                        r_denied     <= 1'b1;
                        r_status     <= ST_TIMEOUT;
                        r_valid      <= 1'b0;
                        r_disp_units <= '0;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                    r_valid      <= 1'b0;
                    r_disp_units <= '0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign dispense_valid = r_valid;
    assign dispense_units = r_disp_units;
    assign approved       = r_approved;
    assign denied         = r_denied;
    assign status         = r_status;
    assign balance        = r_balance;
    assign notes_left     = r_notes;

`ifdef ATM_AUDIT_LOG_EN
    logic        w_commit;
    logic [15:0] r_txn_count;

    assign w_commit = ((r_state == CHECK) && !r_is_wd && w_dep_ok)
                   || ((r_state == DISPENSE) && dispense_ack);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_txn_count <= '0;
        end else if (w_commit && (r_txn_count != 16'hFFFF)) begin
            r_txn_count <= r_txn_count + 16'd1;
        end
    end

    assign txn_count = r_txn_count;
`else
    assign txn_count = '0;
`endif

endmodule

// File: tb/tb_atm_cash_vault.sv
// Self-checking bench for atm_cash_vault: directed and randomized transactions against a ledger model.
module tb_atm_cash_vault;
    import atm_vault_pkg::*;

    localparam int BAL_W    = 24;
    localparam int NOTE_W   = 10;
    localparam int T        = 16;
    localparam int BAL_MAX  = (1 << BAL_W) - 1;
    localparam int NOTE_MAX = (1 << NOTE_W) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              W_50000 = 0, W_100000 = 0, W_200000 = 0;
    logic              D_50000 = 0, D_100000 = 0, D_200000 = 0;
    logic              dispense_ack = 0;
    logic              busy, dispense_valid, approved, denied;
    logic [2:0]        dispense_units, status;
    logic [BAL_W-1:0]  balance;
    logic [NOTE_W-1:0] notes_left;
    logic [15:0]       txn_count;

    int n_cmp = 0;
    int n_err = 0;

    int          m_bal   = 40;
    int          m_notes = 100;
    int          m_txn   = 0;
    logic [2:0]  m_status = ST_NONE;

    atm_cash_vault #(
        .BAL_W(BAL_W), .NOTE_W(NOTE_W), .INIT_BALANCE(40), .INIT_NOTES(100), .TIMEOUT_CYCLES(T)
    ) dut (
        .clock(clock), .reset(reset),
        .W_50000(W_50000), .W_100000(W_100000), .W_200000(W_200000),
        .D_50000(D_50000), .D_100000(D_100000), .D_200000(D_200000),
        .dispense_ack(dispense_ack),
        .busy(busy), .dispense_valid(dispense_valid), .dispense_units(dispense_units),
        .approved(approved), .denied(denied), .status(status),
        .balance(balance), .notes_left(notes_left), .txn_count(txn_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_txn();
`ifdef ATM_AUDIT_LOG_EN
        return 16'(m_txn);
`else
        return 16'd0;
`endif
    endfunction

    task automatic clr_req();
        W_50000 = 0; W_100000 = 0; W_200000 = 0;
        D_50000 = 0; D_100000 = 0; D_200000 = 0;
    endtask

    task automatic drive_req(input bit is_wd, input int u);
        if (is_wd) begin
            if (u == 1) W_50000 = 1; else if (u == 2) W_100000 = 1; else W_200000 = 1;
        end else begin
            if (u == 1) D_50000 = 1; else if (u == 2) D_100000 = 1; else D_200000 = 1;
        end
    endtask

    task automatic model_reset();
        m_bal = 40; m_notes = 100; m_txn = 0; m_status = ST_NONE;
    endtask

    task automatic chk_ledger(input string tag);
        chk({tag, ".status"},  32'(status),     32'(m_status));
        chk({tag, ".balance"}, 32'(balance),    32'(m_bal));
        chk({tag, ".notes"},   32'(notes_left), 32'(m_notes));
        chk({tag, ".txn"},     32'(txn_count),  32'(exp_txn()));
    endtask

    // One full transaction. ack_d: dispense cycle on which ack is raised (>= T means never).
    // inj_d: dispense cycle on which a stray deposit request is pulsed (-1 means none).
    task automatic run_txn(input bit is_wd, input int u, input int ack_d, input int inj_d, input string tag);
        int   n_appr = 0, n_den = 0, n_both = 0, res_j = 0, d = 0, exp_j;
        bit   valid_seen = 0, units_bad = 0, busy1 = 0, exp_appr, exp_valid = 0;
        logic [2:0] exp_st;
        if (is_wd) begin
            if (m_bal < u) begin
                exp_appr = 0; exp_st = ST_NOFUNDS; exp_j = 2;
            end else if (m_notes < u) begin
                exp_appr = 0; exp_st = ST_NOCASH; exp_j = 2;
            end else begin
                exp_valid = 1;
                if (ack_d < T) begin exp_appr = 1; exp_st = ST_OK;      exp_j = ack_d + 3; end
                else           begin exp_appr = 0; exp_st = ST_TIMEOUT; exp_j = T + 2;     end
            end
        end else begin
            exp_j = 2;
            if (m_bal + u > BAL_MAX || m_notes + u > NOTE_MAX) begin exp_appr = 0; exp_st = ST_FULL; end
            else begin exp_appr = 1; exp_st = ST_OK; end
        end

        @(negedge clock);
        clr_req();
        drive_req(is_wd, u);
        for (int j = 1; j <= T + 8; j++) begin
            @(negedge clock);
            clr_req();
            dispense_ack = 0;
            if (j == 1) busy1 = busy;
            if (approved && denied) n_both++;
            if (approved) n_appr++;
            if (denied) n_den++;
            if ((approved || denied) && res_j == 0) res_j = j;
            if (dispense_valid) begin
                valid_seen = 1;
                if (dispense_units !== 3'(u)) units_bad = 1;
                if (d == inj_d) D_200000 = 1;
                if (d == ack_d) dispense_ack = 1;
                d++;
            end
            if (res_j != 0 && j > res_j) break;
        end
        clr_req();
        dispense_ack = 0;

        if (exp_appr) begin
            if (is_wd) begin m_bal -= u; m_notes -= u; end
            else       begin m_bal += u; m_notes += u; end
            if (m_txn < 16'hFFFF) m_txn++;
        end
        m_status = exp_st;

        chk({tag, ".approved"},  32'(n_appr),     32'(exp_appr));
        chk({tag, ".denied"},    32'(n_den),      32'(!exp_appr));
        chk({tag, ".latency"},   32'(res_j),      32'(exp_j));
        chk({tag, ".both"},      32'(n_both),     32'd0);
        chk({tag, ".valid"},     32'(valid_seen), 32'(exp_valid));
        chk({tag, ".units"},     32'(units_bad),  32'd0);
        chk({tag, ".busy"},      32'(busy1),      32'd1);
        chk_ledger(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"},     32'(busy),           32'd0);
        chk({tag, ".valid"},    32'(dispense_valid), 32'd0);
        chk({tag, ".dunits"},   32'(dispense_units), 32'd0);
        chk({tag, ".approved"}, 32'(approved),       32'd0);
        chk({tag, ".denied"},   32'(denied),         32'd0);
        chk_ledger(tag);
    endtask

    initial begin
        int u, kind;

        // Power-on reset
        #12;
        chk_reset_vals("por");
        @(negedge clock);
        reset = 0;

        run_txn(1, 2, 3, -1, "w100k_ack3");

        // Reset in the middle of a dispense: no debit, immediate return to reset values
        @(negedge clock);
        W_100000 = 1;
        @(negedge clock);
        clr_req();
        @(negedge clock);
        chk("mid.valid_before", 32'(dispense_valid), 32'd1);
        chk("mid.bal_before",   32'(balance),        32'(m_bal));
        #2 reset = 1;
        #1;
        model_reset();
        chk_reset_vals("mid_rst");
        @(negedge clock);
        reset = 0;

        run_txn(0, 4, 0, -1, "d200k");
        run_txn(1, 1, T + 5, -1, "w50k_timeout");
        run_txn(1, 1, T - 1, -1, "w50k_lastack");

        // Two pulses at once
        @(negedge clock);
        W_50000 = 1; D_100000 = 1;
        @(negedge clock);
        clr_req();
        m_status = ST_ILLEGAL;
        chk("illegal.denied",   32'(denied),   32'd1);
        chk("illegal.approved", 32'(approved), 32'd0);
        chk("illegal.busy",     32'(busy),     32'd0);
        chk_ledger("illegal");
        @(negedge clock);
        chk("illegal.pulse1", 32'(denied), 32'd0);

        run_txn(1, 4, 5, 2, "w200k_inject");

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 1));
            u    = 1 << $urandom_range(0, 2);
            run_txn(kind[0], u, int'($urandom_range(0, T + 2)), int'($urandom_range(0, T)) - 1, "rand");
        end

        // Drain balance down to exactly 1 unit
        while (m_bal > 1) begin
            u = (m_bal - 4 >= 1) ? 4 : ((m_bal - 2 >= 1) ? 2 : 1);
            run_txn(1, u, 1, -1, "drain");
        end
        run_txn(1, 4, 0, -1, "nofunds_200k");
        run_txn(1, 2, 0, -1, "nofunds_100k");
        run_txn(1, 1, 2, -1, "exact_last");
        run_txn(1, 1, 0, -1, "nofunds_zero");

        // Fill the note cassette up to its exact maximum
        while (m_notes < NOTE_MAX) begin
            u = (m_notes + 4 <= NOTE_MAX) ? 4 : ((m_notes + 2 <= NOTE_MAX) ? 2 : 1);
            run_txn(0, u, 0, -1, "fill");
        end
        run_txn(0, 1, 0, -1, "full_50k");
        run_txn(0, 4, 0, -1, "full_200k");
        run_txn(1, 4, 2, -1, "after_full");

        @(negedge clock);
        #2 reset = 1;
        #1;
        model_reset();
        chk_reset_vals("final_rst");
        @(negedge clock);
        reset = 0;
        run_txn(1, 1, 0, -1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/atm_cash_vault.md
Name: atm_cash_vault

Overview:
Back-end responder for the ATM controller's transaction outputs. It consumes the six one-hot request pulses (W_50000/W_100000/W_200000/D_50000/D_100000/D_200000) and checks funds and note stock. It drives a dispense handshake to the cash mechanism and commits balance and note-count updates. It reports approved/denied per transaction so the controller side can end the session.

Parameters:
BAL_W, 24, balance width in units of 50,000 (1 unit = one 50,000 note)
NOTE_W, 10, cassette note-count width (50,000 notes only)
INIT_BALANCE, 40, balance loaded on reset (units)
INIT_NOTES, 100, notes loaded on reset
TIMEOUT_CYCLES, 16, cycles in DISPENSE without ack before retract (min 1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
W_50000 / W_100000 / W_200000  in  1 each  withdraw request pulses, 1 cycle
D_50000 / D_100000 / D_200000  in  1 each  deposit request pulses, 1 cycle
dispense_ack  in  1  mechanism confirms notes taken
busy  out  1  high whenever state != IDLE
dispense_valid  out  1  request to mechanism
dispense_units  out  3  notes to dispense (1, 2 or 4), valid while dispense_valid
approved  out  1  1-cycle pulse, transaction committed
denied  out  1  1-cycle pulse, transaction rejected
status  out  3  last result code, held until the next result
balance  out  BAL_W  current balance (units)
notes_left  out  NOTE_W  current note count
txn_count  out  16  committed-transaction counter (AUDIT_LOG_EN only, else 0)

Behaviour:
- Reset (async, any state): state=IDLE. All pulses, valid and busy outputs = 0; dispense_units=0; status=ST_NONE; balance=INIT_BALANCE; notes_left=INIT_NOTES; txn_count=0. Reset during DISPENSE aborts with no debit.
- Unit mapping: *_50000 → 1, *_100000 → 2, *_200000 → 4.
- IDLE: sampled at edge k:
  - Exactly one request high: latch direction and units; go to CHECK.
  - More than one high: denied=1 and status=ST_ILLEGAL after edge k; stay IDLE.
  - None high: stay in IDLE.
- Requests arriving outside IDLE are ignored. No queueing. status is not changed.
- CHECK (1 cycle, edge k+1):
  - Withdraw: if balance>=u and notes_left>=u, go to DISPENSE. Otherwise denied=1, status=ST_NOFUNDS (balance short, checked first) or ST_NOCASH; go to IDLE.
  - Deposit: if balance+u and notes_left+u both fit their widths (no wrap), add u to both, approved=1, status=ST_OK; go to IDLE. Otherwise denied=1, status=ST_FULL, no change.
  - Deposit latency: approved is visible in the cycle after edge k+1, i.e. 2 cycles after the request.
- DISPENSE: dispense_valid=1 and dispense_units=u, held stable. A timer runs from 0.
  - dispense_ack high at an edge: balance-=u, notes_left-=u, approved=1, status=ST_OK; dispense_valid drops at the same edge; go to IDLE.
  - Ack and timer==TIMEOUT_CYCLES-1 at the same edge: ack wins.
  - Timer reaches TIMEOUT_CYCLES-1 without ack: denied=1, status=ST_TIMEOUT, no debit; go to IDLE.
- dispense_ack outside DISPENSE is ignored.
- approved and denied are never high together. Each pulses exactly once per accepted transaction.
- No arithmetic ever wraps. Subtraction is guarded by CHECK; addition is guarded by the overflow test.

Optional Feature:
ATM_AUDIT_LOG_EN:
- Defined: txn_count increments on every approved pulse and saturates at 16'hFFFF.
- Undefined: txn_count tied to 0 and the counter logic is removed.
- All other behaviour is identical in both builds.

Decomposition:
Package atm_vault_pkg holds:
- state enum {IDLE, CHECK, DISPENSE}
- unit constants UNIT_50K=1, UNIT_100K=2, UNIT_200K=4
- status codes ST_NONE=0, ST_OK=1, ST_NOFUNDS=2, ST_NOCASH=3, ST_FULL=4, ST_TIMEOUT=5, ST_ILLEGAL=6

Sub-module atm_req_decode is combinational. It takes the six pulses and outputs req_valid, is_withdraw, units[2:0] and illegal (more than one pulse high).

Test Plan:
- Reset, then W_100000 pulse; ack 3 cycles into DISPENSE → dispense_units=2, approved once, balance 40→38, notes 100→98, status=ST_OK.
- D_200000 pulse from reset → approved exactly 2 cycles after the pulse, no dispense_valid, balance=44, notes=104.
- Balance forced to 1 via deposits/withdrawals, then W_200000 → denied, ST_NOFUNDS, balance and notes unchanged, dispense_valid never asserted.
- W_50000 with ack withheld → denied at cycle TIMEOUT_CYCLES of DISPENSE, ST_TIMEOUT, balance unchanged. Repeat with ack on the final cycle → approved, not denied.
- W_50000 and D_100000 in the same cycle → denied next cycle, ST_ILLEGAL. A second request pulsed during DISPENSE is ignored.
- Reset asserted mid-DISPENSE → outputs return to reset values immediately (async), no debit. With ATM_AUDIT_LOG_EN, txn_count=0 after reset and 1 after one approved transaction.
